// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: state encoding, checksum width and
// default placement of the program image in code memory.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CHECK   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    localparam int          CHECKSUM_W             = 8;
    localparam logic [31:0] DEFAULT_BASE_ADDR      = 32'h0000_0000;
    localparam int          DEFAULT_MEM_BYTES      = 256;
    localparam int          DEFAULT_RELEASE_CYCLES = 8;

    // Byte address of payload byte 'offset'; wraps at 32 bits by construction.
    function automatic logic [31:0] byte_addr(input logic [31:0] base,
                                              input logic [31:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// 8-bit modular accumulator over every accepted beat (payload plus checksum byte);
// a good image sums to zero.
module loader_checksum
    import program_loader_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_add_en,
    input  logic [CHECKSUM_W-1:0] i_data,
    output logic [CHECKSUM_W-1:0] o_sum,
    output logic                  o_zero
);

    logic [CHECKSUM_W-1:0] r_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else if (i_add_en) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum  = r_sum;
    assign o_zero = (r_sum == '0);

endmodule

// File: rtl/program_loader.sv
// Streams a program image into code memory while holding the CPU in reset, then
// checks the image checksum and releases the CPU on a full clock-phase rotation.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter int          MEM_BYTES      = DEFAULT_MEM_BYTES,
    parameter int          RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load_start,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_last,
    output logic        o_in_ready,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    output logic        o_cpu_reset,
    output logic        o_done,
    output logic        o_error,
    output logic [31:0] o_byte_count
);

    localparam int          REL_W       = $clog2(RELEASE_CYCLES + 1);
    localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_byte_count;
    logic [REL_W-1:0]   r_rel_cnt;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [7:0]         r_mem_wdata;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_full;
    logic               w_write;
    logic               w_start;
    logic               w_sum_add;
    logic               w_sum_zero;
    logic [CHECKSUM_W-1:0] w_sum;

    assign w_in_ready = (r_state == ST_LOAD);
    assign w_accept   = i_in_valid & w_in_ready;
    assign w_full     = (r_byte_count >= MEM_BYTES_W);
    assign w_write    = w_accept & ~i_in_last & ~w_full;
    // A start request is only honoured outside LOAD; CHECK and RELEASE also ignore it.
    assign w_start    = i_load_start &
                        ((r_state == ST_IDLE) | (r_state == ST_DONE) | (r_state == ST_ERROR));
    assign w_sum_add  = w_accept & (i_in_last | ~w_full);

    loader_checksum u_checksum (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_start),
        .i_add_en (w_sum_add),
        .i_data   (i_in_data),
        .o_sum    (w_sum),
        .o_zero   (w_sum_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_load_start) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (i_in_last)   w_state_next = ST_CHECK;
                    else if (w_full) w_state_next = ST_ERROR;
                end
            end
            ST_CHECK: begin
                w_state_next = w_sum_zero ? ST_RELEASE : ST_ERROR;
            end
            ST_RELEASE: begin
                if (r_rel_cnt == REL_LAST) w_state_next = ST_DONE;
            end
            ST_DONE, ST_ERROR: begin
                if (i_load_start) w_state_next = ST_LOAD;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready  = w_in_ready;
        o_cpu_reset = (r_state != ST_DONE);
        o_done      = (r_state == ST_DONE);
        o_error     = (r_state == ST_ERROR);
    end

    // Memory write port is registered so each write lands one cycle after its beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_count <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= BASE_ADDR;
            r_mem_wdata  <= '0;
        end else begin
            r_mem_we <= w_write;
            if (w_start) begin
                r_byte_count <= '0;
            end else if (w_write) begin
                r_byte_count <= r_byte_count + 32'd1;
            end
            if (w_write) begin
                r_mem_addr  <= byte_addr(BASE_ADDR, r_byte_count);
                r_mem_wdata <= i_in_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rel_cnt <= '0;
        end else if (r_state == ST_RELEASE) begin
            r_rel_cnt <= r_rel_cnt + 1'b1;
        end else begin
            r_rel_cnt <= '0;
        end
    end

    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_byte_count = r_byte_count;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good/bad images, gaps, overflow on a small
// instance, reset mid-load, ignored restart and the checksum-only image.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        load_start, in_valid, in_last;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, cpu_reset, done, error;
    logic [31:0] mem_addr, byte_count;
    logic [7:0]  mem_wdata;

    logic        load_start_o, in_valid_o, in_last_o;
    logic [7:0]  in_data_o;
    logic        in_ready_o, mem_we_o, cpu_reset_o, done_o, error_o;
    logic [31:0] mem_addr_o, byte_count_o;
    logic [7:0]  mem_wdata_o;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    program_loader u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_start(load_start),
        .i_in_valid(in_valid), .i_in_data(in_data), .i_in_last(in_last),
        .o_in_ready(in_ready), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_cpu_reset(cpu_reset), .o_done(done),
        .o_error(error), .o_byte_count(byte_count)
    );

    program_loader #(.MEM_BYTES(4)) u_dut_ovf (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_start(load_start_o),
        .i_in_valid(in_valid_o), .i_in_data(in_data_o), .i_in_last(in_last_o),
        .o_in_ready(in_ready_o), .o_mem_we(mem_we_o), .o_mem_addr(mem_addr_o),
        .o_mem_wdata(mem_wdata_o), .o_cpu_reset(cpu_reset_o), .o_done(done_o),
        .o_error(error_o), .o_byte_count(byte_count_o)
    );

    always @(negedge clk) if (mem_we === 1'b1) wr_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input string tag);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk({tag, "_ready"}, in_ready, 1);
        chk({tag, "_cpu_reset"}, cpu_reset, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_count"}, byte_count, 0);
    endtask

    task automatic send_beat(input string tag, input logic [7:0] data, input logic last,
                             input logic exp_wr, input logic [31:0] exp_addr);
        chk({tag, "_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_we"}, mem_we, exp_wr);
        if (exp_wr) begin
            chk({tag, "_addr"}, mem_addr, exp_addr);
            chk({tag, "_wdata"}, mem_wdata, data);
        end
        $display("beat %s data=%h last=%0b we=%0b addr=%h", tag, data, last, mem_we, mem_addr);
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            chk({tag, "_hold_reset"}, cpu_reset, 1);
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_cycles);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_cpu_reset"}, cpu_reset, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_ready"}, in_ready, 0);
    endtask

    task automatic good_image(input string tag);
        logic [7:0] img [5] = '{8'hB8, 8'h02, 8'h00, 8'h00, 8'h00};
        start_load(tag);
        for (int i = 0; i < 5; i++) send_beat(tag, img[i], 1'b0, 1'b1, i);
        send_beat({tag, "_sum"}, 8'h46, 1'b1, 1'b0, 0);
        wait_done(tag, 9);
        chk({tag, "_count"}, byte_count, 5);
    endtask

    initial begin
        logic [7:0] img [5] = '{8'hB8, 8'h02, 8'h00, 8'h00, 8'h00};
        logic       gap_v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] gap_d [3] = '{8'h11, 8'h22, 8'h33};
        int base;
        int idx;

        rst_n = 1'b0;
        load_start = 0; in_valid = 0; in_data = 0; in_last = 0;
        load_start_o = 0; in_valid_o = 0; in_data_o = 0; in_last_o = 0;
        tick(); tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_count", byte_count, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", in_ready, 0);

        good_image("good");

        start_load("bad");
        for (int i = 0; i < 5; i++) send_beat("bad", img[i], 1'b0, 1'b1, i);
        send_beat("bad_sum", 8'h47, 1'b1, 1'b0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bad_error", error, 1);
            chk("bad_done", done, 0);
            chk("bad_cpu_reset", cpu_reset, 1);
            chk("bad_count", byte_count, 5);
            tick();
        end
        good_image("recover");

        load_start_o = 1'b1;
        tick();
        load_start_o = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("ovf_ready", in_ready_o, 1);
            in_valid_o = 1'b1;
            in_data_o  = 8'(i + 1);
            tick();
            in_valid_o = 1'b0;
            chk("ovf_we", mem_we_o, (i < 4) ? 1 : 0);
            if (i < 4) chk("ovf_addr", mem_addr_o, i);
            $display("beat ovf data=%h we=%0b addr=%h", in_data_o, mem_we_o, mem_addr_o);
        end
        chk("ovf_error", error_o, 1);
        chk("ovf_count", byte_count_o, 4);
        chk("ovf_ready_after", in_ready_o, 0);

        start_load("gap");
        base = wr_cnt;
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            if (gap_v[k]) begin
                send_beat("gap", gap_d[idx], 1'b0, 1'b1, idx);
                idx++;
            end else begin
                tick();
                chk("gap_idle_we", mem_we, 0);
            end
        end
        send_beat("gap_sum", 8'h9A, 1'b1, 1'b0, 0);
        wait_done("gap", 9);
        chk("gap_writes", wr_cnt - base, 3);
        chk("gap_count", byte_count, 3);

        start_load("abort");
        send_beat("abort", 8'hA1, 1'b0, 1'b1, 0);
        send_beat("abort", 8'hA2, 1'b0, 1'b1, 1);
        in_valid = 1'b1; in_data = 8'hA3;
        rst_n = 1'b0;
        #1;
        chk("abort_we", mem_we, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_cpu_reset", cpu_reset, 1);
        chk("abort_count", byte_count, 0);
        chk("abort_addr", mem_addr, 0);
        tick();
        in_valid = 1'b0;
        chk("abort_we_hold", mem_we, 0);
        rst_n = 1'b1;
        tick();
        chk("abort_idle_ready", in_ready, 0);
        chk("abort_idle_done", done, 0);
        good_image("reload");

        start_load("ign");
        send_beat("ign", 8'h01, 1'b0, 1'b1, 0);
        send_beat("ign", 8'h02, 1'b0, 1'b1, 1);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("ign_count", byte_count, 2);
        chk("ign_ready", in_ready, 1);
        send_beat("ign_sum", 8'hFD, 1'b1, 1'b0, 0);
        wait_done("ign", 9);
        chk("ign_final_count", byte_count, 2);

        start_load("empty");
        base = wr_cnt;
        send_beat("empty_sum", 8'h00, 1'b1, 1'b0, 0);
        wait_done("empty", 9);
        chk("empty_count", byte_count, 0);
        chk("empty_writes", wr_cnt - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
